slave_port_controller: RTL and testbench



---
 rtl/slave_port_controller.sv | 150 +++++++++++++++
 tb/tb_slave_port_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port_controller.sv
// Per-slave port controller sitting directly behind the slave's round-robin arbiter.
// It latches the granted master, forwards that master's request to the slave and
// routes ack / read response / read data back to the owner only. When the
// transaction completes it pulses session_is_finished to release the arbiter.
//
// Handshake rules: in REQ the slave accepts when s_req && s_ack in the same
// cycle; in RESP the read data is valid (and consumed) in the cycle s_resp is
// high. Acks and responses outside those states are ignored.
module slave_port_controller #(
  parameter int N_MASTERS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            grant,
  input  logic [N_MASTERS-1:0]            m_req,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS-1:0]            m_cmd,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [N_MASTERS-1:0]            m_ack,
  output logic [N_MASTERS-1:0]            m_resp,
  output logic [DATA_WIDTH-1:0]           m_rdata,
  output logic                            s_req,
  output logic [ADDR_WIDTH-1:0]           s_addr,
  output logic                            s_cmd,
  output logic [DATA_WIDTH-1:0]           s_wdata,
  input  logic                            s_ack,
  input  logic                            s_resp,
  input  logic [DATA_WIDTH-1:0]           s_rdata,
  output logic                            session_is_finished,
  output logic                            busy
);

  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       owner_nxt;
  logic [OW-1:0]       grant_idx;
  logic                own_req;
  logic                own_cmd;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;

  // Lowest set grant bit wins, so a non-one-hot grant still picks one master.
  always_comb begin
    grant_idx = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (grant[i]) grant_idx = OW'(i);
    end
  end

  // Select the owner's request, command, address and write data.
  always_comb begin
    own_req   = 1'b0;
    own_cmd   = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (owner == OW'(i)) begin
        own_req   = m_req[i];
        own_cmd   = m_cmd[i];
        own_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State and owner registers; reset abandons any transaction without a finish pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Next-state logic and output decode from state and latched owner.
  always_comb begin
    state_nxt           = state;
    owner_nxt           = owner;
    s_req               = 1'b0;
    s_addr              = '0;
    s_cmd               = 1'b0;
    s_wdata             = '0;
    m_ack               = '0;
    m_resp              = '0;
    m_rdata             = '0;
    session_is_finished = 1'b0;
    busy                = 1'b0;

    case (state)
      IDLE: begin
        // grant is only looked at here; later grant changes cannot move the owner.
        if (grant != '0) begin
          owner_nxt = grant_idx;
          state_nxt = REQ;
        end
      end

      REQ: begin
        busy    = 1'b1;
        s_req   = own_req;
        s_addr  = own_addr;
        s_cmd   = own_cmd;
        s_wdata = own_wdata;
        for (int i = 0; i < N_MASTERS; i++) begin
          if (owner == OW'(i)) m_ack[i] = s_ack;
        end
        if (!own_req) begin
          // Master withdrew before the slave accepted: close the session.
          state_nxt = FIN;
        end else if (s_ack) begin
          state_nxt = own_cmd ? FIN : RESP;
        end
      end

      RESP: begin
        busy = 1'b1;
        for (int i = 0; i < N_MASTERS; i++) begin
          if (owner == OW'(i)) m_resp[i] = s_resp;
        end
        m_rdata = s_rdata;
        if (s_resp) state_nxt = FIN;
      end

      FIN: begin
        busy                = 1'b1;
        session_is_finished = 1'b1;
        state_nxt           = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_slave_port_controller.sv
// Directed bench for slave_port_controller: write, read with waits, non-one-hot
// grant, request withdrawal, stray slave signals, and reset mid-read.
module tb_slave_port_controller;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NM-1:0]     grant;
  logic [NM-1:0]     m_req;
  logic [NM*AW-1:0]  m_addr;
  logic [NM-1:0]     m_cmd;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_resp;
  logic [DW-1:0]     m_rdata;
  logic              s_req;
  logic [AW-1:0]     s_addr;
  logic              s_cmd;
  logic [DW-1:0]     s_wdata;
  logic              s_ack;
  logic              s_resp;
  logic [DW-1:0]     s_rdata;
  logic              session_is_finished;
  logic              busy;

  int n_total;
  int n_pass;

  slave_port_controller #(
    .N_MASTERS (NM),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .grant              (grant),
    .m_req              (m_req),
    .m_addr             (m_addr),
    .m_cmd              (m_cmd),
    .m_wdata            (m_wdata),
    .m_ack              (m_ack),
    .m_resp             (m_resp),
    .m_rdata            (m_rdata),
    .s_req              (s_req),
    .s_addr             (s_addr),
    .s_cmd              (s_cmd),
    .s_wdata            (s_wdata),
    .s_ack              (s_ack),
    .s_resp             (s_resp),
    .s_rdata            (s_rdata),
    .session_is_finished(session_is_finished),
    .busy               (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs checked 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    grant   = '0;
    m_req   = '0;
    m_addr  = '0;
    m_cmd   = '0;
    m_wdata = '0;
    s_ack   = 1'b0;
    s_resp  = 1'b0;
    s_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_req"},   64'(s_req), 64'd0);
    chk({tag, "_s_addr"},  64'(s_addr), 64'd0);
    chk({tag, "_s_cmd"},   64'(s_cmd), 64'd0);
    chk({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
    chk({tag, "_m_ack"},   64'(m_ack), 64'd0);
    chk({tag, "_m_resp"},  64'(m_resp), 64'd0);
    chk({tag, "_m_rdata"}, 64'(m_rdata), 64'd0);
    chk({tag, "_fin"},     64'(session_is_finished), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clear_inputs();
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    // ---- Write, master 2, immediate ack ----
    grant = 4'b0100;
    m_req = 4'b0100;
    m_cmd = 4'b0100;
    m_addr[2*AW +: AW]  = 32'h4000_0010;
    m_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
    s_ack = 1'b1;
    #1;
    chk("wr_idle_busy", 64'(busy), 64'd0);
    chk("wr_idle_m_ack", 64'(m_ack), 64'd0);
    tick();
    grant = '0;
    chk("wr_req_s_req", 64'(s_req), 64'd1);
    chk("wr_req_s_addr", 64'(s_addr), 64'h4000_0010);
    chk("wr_req_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    chk("wr_req_s_cmd", 64'(s_cmd), 64'd1);
    chk("wr_req_m_ack", 64'(m_ack), 64'b0100);
    chk("wr_req_fin", 64'(session_is_finished), 64'd0);
    chk("wr_req_busy", 64'(busy), 64'd1);
    tick();
    chk("wr_fin_pulse", 64'(session_is_finished), 64'd1);
    chk("wr_fin_s_req", 64'(s_req), 64'd0);
    chk("wr_fin_s_addr", 64'(s_addr), 64'd0);
    chk("wr_fin_m_ack", 64'(m_ack), 64'd0);
    chk("wr_fin_busy", 64'(busy), 64'd1);
    clear_inputs();
    tick();
    chk("wr_idle2_fin", 64'(session_is_finished), 64'd0);
    chk("wr_idle2_busy", 64'(busy), 64'd0);

    // ---- Read, master 1, ack after 3 cycles, resp 2 cycles later ----
    // Stray s_resp in IDLE is ignored.
    s_resp = 1'b1;
    grant  = 4'b0010;
    m_req  = 4'b0010;
    m_addr[1*AW +: AW] = 32'h0000_0200;
    #1;
    chk("rd_idle_stray_resp", 64'(m_resp), 64'd0);
    tick();
    s_resp = 1'b0;
    grant  = '0;
    chk("rd_req1_s_req", 64'(s_req), 64'd1);
    chk("rd_req1_s_addr", 64'(s_addr), 64'h0000_0200);
    chk("rd_req1_s_cmd", 64'(s_cmd), 64'd0);
    chk("rd_req1_m_ack", 64'(m_ack), 64'd0);
    tick();
    chk("rd_req2_s_req", 64'(s_req), 64'd1);
    tick();
    s_ack = 1'b1;
    #1;
    chk("rd_req3_s_req", 64'(s_req), 64'd1);
    chk("rd_req3_m_ack", 64'(m_ack), 64'b0010);
    tick();
    s_ack = 1'b0;
    grant = 4'b1000;   // grant change during RESP must not affect owner
    chk("rd_resp1_s_req", 64'(s_req), 64'd0);
    chk("rd_resp1_m_ack", 64'(m_ack), 64'd0);
    chk("rd_resp1_m_resp", 64'(m_resp), 64'd0);
    chk("rd_resp1_busy", 64'(busy), 64'd1);
    tick();
    s_resp  = 1'b1;
    s_rdata = 32'h1234_5678;
    #1;
    chk("rd_resp2_m_resp", 64'(m_resp), 64'b0010);
    chk("rd_resp2_m_rdata", 64'(m_rdata), 64'h1234_5678);
    chk("rd_resp2_fin", 64'(session_is_finished), 64'd0);
    tick();
    clear_inputs();
    chk("rd_fin_pulse", 64'(session_is_finished), 64'd1);
    chk("rd_fin_m_resp", 64'(m_resp), 64'd0);
    tick();
    chk("rd_idle_fin", 64'(session_is_finished), 64'd0);
    chk("rd_idle_busy", 64'(busy), 64'd0);

    // ---- Non-one-hot grant 1010: owner is master 1, master 3 sees nothing ----
    grant = 4'b1010;
    m_req = 4'b1010;
    m_cmd = 4'b1010;
    m_addr[1*AW +: AW]  = 32'h1111_0000;
    m_addr[3*AW +: AW]  = 32'h3333_0000;
    m_wdata[1*DW +: DW] = 32'hAAAA_0001;
    m_wdata[3*DW +: DW] = 32'hBBBB_0003;
    tick();
    grant  = '0;
    s_ack  = 1'b1;
    s_resp = 1'b1;   // stray response in REQ
    #1;
    chk("nh_s_addr", 64'(s_addr), 64'h1111_0000);
    chk("nh_s_wdata", 64'(s_wdata), 64'hAAAA_0001);
    chk("nh_m_ack", 64'(m_ack), 64'b0010);
    chk("nh_stray_resp", 64'(m_resp), 64'd0);
    tick();
    clear_inputs();
    chk("nh_fin_pulse", 64'(session_is_finished), 64'd1);
    tick();
    chk("nh_idle_busy", 64'(busy), 64'd0);

    // ---- Master 0 withdraws request before ack ----
    grant = 4'b0001;
    m_req = 4'b0001;
    m_cmd = 4'b0001;
    m_addr[0*AW +: AW] = 32'h0000_00F0;
    tick();
    grant = '0;
    chk("wd_req_s_req", 64'(s_req), 64'd1);
    tick();
    m_req = '0;
    #1;
    chk("wd_drop_s_req", 64'(s_req), 64'd0);
    chk("wd_drop_m_ack", 64'(m_ack), 64'd0);
    tick();
    chk("wd_fin_pulse", 64'(session_is_finished), 64'd1);
    tick();
    chk("wd_idle_fin", 64'(session_is_finished), 64'd0);
    chk("wd_idle_busy", 64'(busy), 64'd0);

    // ---- Reset during RESP ----
    grant = 4'b0001;
    m_req = 4'b0001;
    m_cmd = 4'b0000;
    m_addr[0*AW +: AW] = 32'h0000_0ABC;
    s_ack = 1'b1;
    tick();
    grant = '0;
    chk("rr_req_m_ack", 64'(m_ack), 64'b0001);
    tick();
    s_ack   = 1'b0;
    s_resp  = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    #1;
    chk("rr_resp_m_resp", 64'(m_resp), 64'b0001);
    chk("rr_resp_m_rdata", 64'(m_rdata), 64'hCAFE_F00D);
    rst = 1'b1;
    #1;
    chk_all_zero("rr_async");
    tick();
    chk("rr_held_fin", 64'(session_is_finished), 64'd0);
    rst = 1'b0;
    clear_inputs();
    tick();
    chk("rr_post_fin", 64'(session_is_finished), 64'd0);
    chk("rr_post_busy", 64'(busy), 64'd0);

    // Fresh write after reset: master 3
    grant = 4'b1000;
    m_req = 4'b1000;
    m_cmd = 4'b1000;
    m_addr[3*AW +: AW]  = 32'h8000_0004;
    m_wdata[3*DW +: DW] = 32'h0BAD_F00D;
    s_ack = 1'b1;
    tick();
    grant = '0;
    chk("fr_s_addr", 64'(s_addr), 64'h8000_0004);
    chk("fr_s_wdata", 64'(s_wdata), 64'h0BAD_F00D);
    chk("fr_m_ack", 64'(m_ack), 64'b1000);
    tick();
    clear_inputs();
    chk("fr_fin_pulse", 64'(session_is_finished), 64'd1);
    tick();
    chk("fr_idle_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
